// File: rtl/tetris_vga_pkg.sv
// -----------------------------------------------------------------------------
// tetris_vga_pkg
// Shared VGA definitions for the Tetris display path:
//   - default 640x480@60 Hz timing constants (active, porches, sync, totals)
//   - row / column typedefs used between the sync generator and colour logic
//   - screen-region constants used by the colour logic
//   - small helper for half-open range tests on counters
// No ports (package).
// -----------------------------------------------------------------------------
package tetris_vga_pkg;

    typedef logic [8:0] vga_row_t;
    typedef logic [9:0] vga_col_t;

    // Default horizontal timing (pixels)
    localparam logic [9:0] DEF_H_ACTIVE = 10'd640;
    localparam logic [9:0] DEF_H_FP     = 10'd16;
    localparam logic [9:0] DEF_H_SYNC   = 10'd96;
    localparam logic [9:0] DEF_H_BP     = 10'd48;
    localparam logic [9:0] DEF_H_TOTAL  = 10'd800;

    // Default vertical timing (lines)
    localparam logic [9:0] DEF_V_ACTIVE = 10'd480;
    localparam logic [9:0] DEF_V_FP     = 10'd10;
    localparam logic [9:0] DEF_V_SYNC   = 10'd2;
    localparam logic [9:0] DEF_V_BP     = 10'd33;
    localparam logic [9:0] DEF_V_TOTAL  = 10'd525;

    // Idle {blank_n, hsync, vsync}: blanked, both syncs released
    localparam logic [2:0] SYNC_IDLE = 3'b011;

    // Screen regions drawn by the colour logic
    localparam vga_col_t PF_X0   = 10'd220;
    localparam vga_col_t PF_X1   = 10'd420;
    localparam vga_row_t PF_Y0   = 9'd40;
    localparam vga_row_t PF_Y1   = 9'd440;
    localparam vga_col_t NEXT_X0 = 10'd460;
    localparam vga_row_t NEXT_Y0 = 9'd60;
    localparam logic [4:0] CELL_PX = 5'd20;

    // True when lo <= v < hi
    function automatic logic in_range(input logic [9:0] v,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// -----------------------------------------------------------------------------
// sync_delay_line
// Depth-DEPTH, 3-bit shift register advancing only when i_en is high. Used to
// line up {blank_n, hsync, vsync} with the pixel data read from board RAM.
// DEPTH = 0 is a straight pass-through.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset, loads RST_VAL into every stage
//   i_en     shift enable (pixel tick)
//   i_d      triple entering the line
//   o_q      triple leaving the line
// -----------------------------------------------------------------------------
module sync_delay_line #(
    parameter int unsigned DEPTH   = 1,
    parameter logic [2:0]  RST_VAL = 3'b011
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [2:0] i_d,
    output logic [2:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused_ok;
            assign w_unused_ok = ^{i_clk, i_rst_n, i_en};
            assign o_q = i_d;
        end else begin : g_pipe
            logic [2:0] r_stage [DEPTH];

            // Shift chain: stage 0 takes the input, later stages take their predecessor
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RST_VAL;
                    end
                end else if (i_en) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// 640x480@60 Hz VGA raster timing generator with a once-per-frame tick.
// Build option: define VGA_PIXEL_DIV2_EN when clk is 50 MHz; pix_en then
// toggles every clock. Left undefined, clk is the 25 MHz pixel clock and
// pix_en is held high.
// Ports:
//   clk         clock (25 MHz, or 50 MHz with VGA_PIXEL_DIV2_EN)
//   rst         asynchronous active-low reset
//   pix_en      pixel tick, counters advance only when high
//   column      horizontal count 0..H_TOTAL-1
//   row         low 9 bits of vertical count
//   blank_n     high inside the visible area (delayed by PIPE_DELAY ticks)
//   hsync       active-low horizontal sync (delayed)
//   vsync       active-low vertical sync (delayed)
//   frame_tick  one-clock pulse as the raster enters line V_ACTIVE, column 0
// -----------------------------------------------------------------------------
module vga_sync_gen
    import tetris_vga_pkg::*;
#(
    parameter logic [9:0]  H_ACTIVE   = DEF_H_ACTIVE,
    parameter logic [9:0]  H_FP       = DEF_H_FP,
    parameter logic [9:0]  H_SYNC     = DEF_H_SYNC,
    parameter logic [9:0]  H_BP       = DEF_H_BP,
    parameter logic [9:0]  V_ACTIVE   = DEF_V_ACTIVE,
    parameter logic [9:0]  V_FP       = DEF_V_FP,
    parameter logic [9:0]  V_SYNC     = DEF_V_SYNC,
    parameter logic [9:0]  V_BP       = DEF_V_BP,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] column,
    output logic [8:0] row,
    output logic       blank_n,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] HS_START = H_ACTIVE + H_FP;
    localparam logic [9:0] HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam logic [9:0] VS_START = V_ACTIVE + V_FP;
    localparam logic [9:0] VS_END   = V_ACTIVE + V_FP + V_SYNC;

    // Full-width sums catch totals that would silently wrap in 10 bits
    localparam int unsigned H_SUM = 32'(H_ACTIVE) + 32'(H_FP) + 32'(H_SYNC) + 32'(H_BP);
    localparam int unsigned V_SUM = 32'(V_ACTIVE) + 32'(V_FP) + 32'(V_SYNC) + 32'(V_BP);

    if ((H_SUM > 32'd1023) || (V_SUM > 32'd1023)) begin : g_bad_totals
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1023");
    end
    if (PIPE_DELAY > 32'd3) begin : g_bad_delay
        $error("vga_sync_gen: PIPE_DELAY must be 0..3");
    end

    logic       r_pix_en;
    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic [2:0] r_raw;
    logic       r_frame_tick;

    logic [9:0] w_h_nxt;
    logic [9:0] w_v_nxt;
    logic [2:0] w_raw_nxt;
    logic       w_frame_nxt;
    logic [2:0] w_dly_q;

    // Pixel tick generation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_en <= 1'b0;
        end else begin
`ifdef VGA_PIXEL_DIV2_EN
            r_pix_en <= ~r_pix_en;
`else
            r_pix_en <= 1'b1;
`endif
        end
    end

    // Next raster position, raw triple and frame-tick decode
    always_comb begin
        w_h_nxt = r_hcount;
        w_v_nxt = r_vcount;
        if (r_pix_en) begin
            if (r_hcount == H_TOTAL - 10'd1) begin
                w_h_nxt = 10'd0;
                if (r_vcount == V_TOTAL - 10'd1) begin
                    w_v_nxt = 10'd0;
                end else begin
                    w_v_nxt = r_vcount + 10'd1;
                end
            end else begin
                w_h_nxt = r_hcount + 10'd1;
            end
        end else begin
            w_h_nxt = r_hcount;
        end
        // The raw triple is decoded from the position the counters are
        // about to hold, so r_raw lines up with column/row at zero delay.
        w_raw_nxt = {(w_h_nxt < H_ACTIVE) && (w_v_nxt < V_ACTIVE),
                     ~in_range(w_h_nxt, HS_START, HS_END),
                     ~in_range(w_v_nxt, VS_START, VS_END)};
        w_frame_nxt = r_pix_en && (r_hcount == H_TOTAL - 10'd1)
                               && (r_vcount == V_ACTIVE - 10'd1);
    end

    // Raster counters, aligned raw triple and frame tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcount     <= 10'd0;
            r_vcount     <= 10'd0;
            r_raw        <= SYNC_IDLE;
            r_frame_tick <= 1'b0;
        end else begin
            r_hcount     <= w_h_nxt;
            r_vcount     <= w_v_nxt;
            r_raw        <= w_raw_nxt;
            r_frame_tick <= w_frame_nxt;
        end
    end

    sync_delay_line #(
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (SYNC_IDLE)
    ) u_delay (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_en    (r_pix_en),
        .i_d     (r_raw),
        .o_q     (w_dly_q)
    );

    assign pix_en                   = r_pix_en;
    assign column                   = r_hcount;
    assign row                      = r_vcount[8:0];
    assign {blank_n, hsync, vsync}  = w_dly_q;
    assign frame_tick               = r_frame_tick;

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
// Directed bench for vga_sync_gen (default build, 25 MHz pixel clock).
// Three full-timing instances (PIPE_DELAY 1, 0, 3) share one reset; a fourth
// instance with shrunken timing (25 x 15 raster) covers whole-frame behaviour.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

    logic clk;
    logic rst;
    logic rst_small;

    logic       pix_en_1, blank_n_1, hsync_1, vsync_1, frame_tick_1;
    logic [9:0] column_1;
    logic [8:0] row_1;
    logic       pix_en_0, blank_n_0, hsync_0, vsync_0, frame_tick_0;
    logic [9:0] column_0;
    logic [8:0] row_0;
    logic       pix_en_3, blank_n_3, hsync_3, vsync_3, frame_tick_3;
    logic [9:0] column_3;
    logic [8:0] row_3;
    logic       pix_en_s, blank_n_s, hsync_s, vsync_s, frame_tick_s;
    logic [9:0] column_s;
    logic [8:0] row_s;

    int checks;
    int failures;
    int edges;

    vga_sync_gen #(.PIPE_DELAY(1)) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en_1), .column(column_1), .row(row_1),
        .blank_n(blank_n_1), .hsync(hsync_1), .vsync(vsync_1), .frame_tick(frame_tick_1)
    );

    vga_sync_gen #(.PIPE_DELAY(0)) dut_d0 (
        .clk(clk), .rst(rst), .pix_en(pix_en_0), .column(column_0), .row(row_0),
        .blank_n(blank_n_0), .hsync(hsync_0), .vsync(vsync_0), .frame_tick(frame_tick_0)
    );

    vga_sync_gen #(.PIPE_DELAY(3)) dut_d3 (
        .clk(clk), .rst(rst), .pix_en(pix_en_3), .column(column_3), .row(row_3),
        .blank_n(blank_n_3), .hsync(hsync_3), .vsync(vsync_3), .frame_tick(frame_tick_3)
    );

    // Small raster: H 16+2+4+3 = 25, V 8+2+2+3 = 15, frame = 375 ticks
    vga_sync_gen #(
        .H_ACTIVE(10'd16), .H_FP(10'd2), .H_SYNC(10'd4), .H_BP(10'd3),
        .V_ACTIVE(10'd8),  .V_FP(10'd2), .V_SYNC(10'd2), .V_BP(10'd3),
        .PIPE_DELAY(1)
    ) dut_small (
        .clk(clk), .rst(rst_small), .pix_en(pix_en_s), .column(column_s), .row(row_s),
        .blank_n(blank_n_s), .hsync(hsync_s), .vsync(vsync_s), .frame_tick(frame_tick_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One pixel tick; sample at the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        edges++;
    endtask

    typedef struct {
        int   e;     // rising edges since reset release
        int   col;
        int   row;
        logic bl1;   // blank_n, PIPE_DELAY=1
        logic hs1;
        logic vs1;
        logic bl0;   // blank_n, PIPE_DELAY=0
        logic bl3;   // blank_n, PIPE_DELAY=3
    } vec_t;

    vec_t vecs[14];

    initial begin
        int hs_low, bl_hi, fall_col, ft_cnt, vs_low, ft_first, ft_second;
        logic prev_hs;

        checks   = 0;
        failures = 0;
        edges    = 0;

        //            e    col  row bl1   hs1   vs1   bl0   bl3
        vecs[0]  = '{  1,    0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{  2,    1, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{  3,    2, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{  4,    3, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{641,  640, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{642,  641, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{644,  643, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{657,  656, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{658,  657, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{753,  752, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{754,  753, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{800,  799, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{801,    0, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{802,    1, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // ---- reset held for 10 cycles ----
        rst       = 1'b0;
        rst_small = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_pix_en",  int'(pix_en_1),     0);
        chk("rst_column",  int'(column_1),     0);
        chk("rst_row",     int'(row_1),        0);
        chk("rst_blank_n", int'(blank_n_1),    0);
        chk("rst_hsync",   int'(hsync_1),      1);
        chk("rst_vsync",   int'(vsync_1),      1);
        chk("rst_ftick",   int'(frame_tick_1), 0);
        chk("rst_blank_d0", int'(blank_n_0),   0);
        chk("rst_hsync_d3", int'(hsync_3),     1);

        // ---- table-driven first line ----
        rst   = 1'b1;
        edges = 0;
        for (int i = 0; i < 14; i++) begin
            while (edges < vecs[i].e) tick();
            chk($sformatf("v%0d_column", i),  int'(column_1),     vecs[i].col);
            chk($sformatf("v%0d_row", i),     int'(row_1),        vecs[i].row);
            chk($sformatf("v%0d_blank1", i),  int'(blank_n_1),    int'(vecs[i].bl1));
            chk($sformatf("v%0d_hsync1", i),  int'(hsync_1),      int'(vecs[i].hs1));
            chk($sformatf("v%0d_vsync1", i),  int'(vsync_1),      int'(vecs[i].vs1));
            chk($sformatf("v%0d_blank0", i),  int'(blank_n_0),    int'(vecs[i].bl0));
            chk($sformatf("v%0d_blank3", i),  int'(blank_n_3),    int'(vecs[i].bl3));
            chk($sformatf("v%0d_pix_en", i),  int'(pix_en_1),     1);
            chk($sformatf("v%0d_ftick", i),   int'(frame_tick_1), 0);
        end

        // ---- one full visible line: pulse widths and hsync fall position ----
        hs_low = 0; bl_hi = 0; fall_col = -1; ft_cnt = 0;
        prev_hs = hsync_1;
        repeat (800) begin
            tick();
            if (!hsync_1) hs_low++;
            if (blank_n_1) bl_hi++;
            if (prev_hs && !hsync_1) fall_col = int'(column_1);
            if (frame_tick_1) ft_cnt++;
            prev_hs = hsync_1;
        end
        chk("line_hsync_low", hs_low,   96);
        chk("line_blank_hi",  bl_hi,    640);
        chk("line_hs_fall",   fall_col, 657);
        chk("line_no_ftick",  ft_cnt,   0);

        // ---- reset in the middle of an hsync pulse ----
        while (edges < 2301) tick();
        chk("pre_rst_column", int'(column_1), 700);
        chk("pre_rst_hsync",  int'(hsync_1),  0);
        rst = 1'b0;
        #1;
        chk("mid_rst_column",  int'(column_1),  0);
        chk("mid_rst_row",     int'(row_1),     0);
        chk("mid_rst_hsync",   int'(hsync_1),   1);
        chk("mid_rst_blank",   int'(blank_n_1), 0);
        chk("mid_rst_pix_en",  int'(pix_en_1),  0);
        chk("mid_rst_hsync3",  int'(hsync_3),   1);
        @(negedge clk);
        rst   = 1'b1;
        edges = 0;
        tick();
        chk("restart_col0",   int'(column_1),  0);
        chk("restart_blank0", int'(blank_n_1), 0);
        tick();
        chk("restart_col1",   int'(column_1),  1);
        chk("restart_blank1", int'(blank_n_1), 1);
        hs_low = 0; fall_col = -1;
        prev_hs = hsync_1;
        repeat (798) begin
            tick();
            if (!hsync_1) hs_low++;
            if (prev_hs && !hsync_1) fall_col = int'(column_1);
            prev_hs = hsync_1;
        end
        chk("restart_hsync_low", hs_low,   96);
        chk("restart_hs_fall",   fall_col, 657);

        // ---- small raster: two frames of frame_tick and vsync ----
        chk("small_rst_vsync", int'(vsync_s), 1);
        rst_small = 1'b1;
        edges = 0;
        ft_cnt = 0; vs_low = 0; ft_first = -1; ft_second = -1;
        repeat (760) begin
            tick();
            if (frame_tick_s) begin
                ft_cnt++;
                chk("small_ftick_row", int'(row_s),    8);
                chk("small_ftick_col", int'(column_s), 0);
                if (ft_first < 0) ft_first = edges;
                else if (ft_second < 0) ft_second = edges;
            end
            if (!vsync_s) vs_low++;
        end
        chk("small_ftick_count",  ft_cnt,              2);
        chk("small_ftick_first",  ft_first,            201);
        chk("small_ftick_period", ft_second - ft_first, 375);
        chk("small_vsync_low",    vs_low,              100);

        // ---- small raster: reset at row 5, column 10 ----
        while (edges < 886) tick();
        chk("small_pre_rst_row", int'(row_s),    5);
        chk("small_pre_rst_col", int'(column_s), 10);
        rst_small = 1'b0;
        #1;
        chk("small_rst_row",   int'(row_s),     0);
        chk("small_rst_col",   int'(column_s),  0);
        chk("small_rst_blank", int'(blank_n_s), 0);
        @(negedge clk);
        rst_small = 1'b1;
        edges = 0;
        ft_first = -1; vs_low = 0;
        repeat (400) begin
            tick();
            if (frame_tick_s && (ft_first < 0)) ft_first = edges;
            if (!vsync_s) vs_low++;
        end
        chk("small_restart_ftick", ft_first, 201);
        chk("small_restart_vsync", vs_low,   50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

- Generates 640x480@60 Hz VGA raster timing.
- Drives the `row`, `column` and `blank_n` inputs of the pixel colour logic, plus `hsync`/`vsync` to the DAC and connector.
- Sits between the board clock and the colour path.
- Also supplies a once-per-frame tick that paces the game state machine.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `PIPE_DELAY`, 1, pixel ticks by which `hsync`/`vsync`/`blank_n` lag `row`/`column` (range 0..3), matching board-RAM read latency
- `clk` in 1: single clock, 50 MHz or 25 MHz (see Configuration)
- `rst` in 1: asynchronous, active-low reset
- `pix_en` out 1: pixel tick; all counters advance only when high
- `column` out 10: horizontal count 0..799
- `row` out 9: low 9 bits of vertical count 0..524
- `blank_n` out 1: high only when the delayed position is inside the 640x480 visible area
- `hsync` out 1: active-low horizontal sync, delayed
- `vsync` out 1: active-low vertical sync, delayed
- `frame_tick` out 1: one-clock pulse, first tick of line `V_ACTIVE`, column 0 (undelayed)

## Operation
- Internal `hcount` (10 b) runs 0..H_TOTAL-1, H_TOTAL=800. It wraps to 0 on the `pix_en` where it equals H_TOTAL-1.
- Internal `vcount` (10 b) runs 0..V_TOTAL-1, V_TOTAL=525. It increments only on the `hcount` wrap and wraps to 0 at V_TOTAL-1 together with `hcount`.
- Outputs: `column` = `hcount`; `row` = `vcount[8:0]`.
  - Row aliasing for `vcount` 512..524 (appears as 0..12) is harmless because `blank_n`=0 there.
- Undelayed raw signals:
  - `act` = (`hcount` < H_ACTIVE) && (`vcount` < V_ACTIVE)
  - `hs_raw` low for `hcount` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656, 752)
  - `vs_raw` low for `vcount` in [490, 492)
- The raw triple passes through a `PIPE_DELAY`-stage shift register that shifts on `pix_en` only.
  - With `PIPE_DELAY`=0, outputs are registered copies aligned to the same tick as `row`/`column`.
- `frame_tick` asserts for exactly one `clk` cycle, coincident with the `pix_en` on which (`vcount`,`hcount`) becomes (V_ACTIVE, 0).
- Parameter sums are computed in 10-bit unsigned arithmetic. H_TOTAL ≤ 1023 and V_TOTAL ≤ 1023 are required, enforced by an elaboration-time check.

## Timing
- Reset (`rst`=0, asynchronous): counters 0, `column`=0, `row`=0, `hsync`=1, `vsync`=1, `blank_n`=0, `frame_tick`=0, `pix_en`=0, all delay stages filled with the inactive triple (blank_n=0, hs=1, vs=1).
- First `pix_en` after reset release:
  - `column`/`row` stay 0 on that tick and advance on the next one.
  - `blank_n` rises `PIPE_DELAY`+1 ticks after reset release.
- All outputs are registered; no combinational path from inputs to outputs.
- Counters move only on `pix_en`; between ticks every output holds.
- Reset mid-frame: immediate return to the reset values. No partial sync pulse is extended, and the frame restarts at (0,0).
- Line period: 800 ticks. Frame period: 420 000 ticks (16.8 ms at 25 MHz pixel rate).

## Configuration
- `VGA_PIXEL_DIV2_EN` defined:
  - `clk` is 50 MHz.
  - `pix_en` toggles every cycle, starting low after reset: first high on the 2nd rising edge after release.
  - Counters advance every other clock.
- Undefined:
  - `clk` is the 25 MHz pixel clock.
  - `pix_en` is held 1 from the first edge after reset release (0 during reset).
  - Counters advance every clock.

## Structure
- Shared package `tetris_vga_pkg` holds:
  - default timing constants (the eight porch/sync/active values, H_TOTAL, V_TOTAL)
  - the 9-bit row and 10-bit column typedefs
  - the screen-region constants used by the colour logic
- One sub-module, `sync_delay_line`: a parameterised depth-`PIPE_DELAY`, 3-bit-wide, enable-gated shift register with async active-low reset to the inactive value.

## Test plan
- Reset held 10 cycles then released, macro undefined, `PIPE_DELAY`=1 → `hsync`=`vsync`=1, `blank_n`=0 during reset; `blank_n`=1 from tick 2 with `column`=1.
- Run one full line → `hsync` low for exactly 96 ticks, falling edge when `column`=657 (one tick delay); `blank_n` high for exactly 640 ticks per visible line.
- Run two full frames → `vsync` low for exactly 1600 ticks per frame; `frame_tick` pulses exactly twice, 420 000 ticks apart, each when `row`=480, `column`=0.
- `VGA_PIXEL_DIV2_EN` defined → `pix_en` alternates 0/1; `column` advances by 1 every 2 clocks; line period 1600 clocks.
- `PIPE_DELAY`=0 vs 3 → `blank_n` rising edge at `column`=0 vs `column`=3 on row 0.
- Assert `rst` low at row 300, column 400 for 1 cycle → all outputs at reset values within that cycle; next frame starts at (0,0) with full-length sync pulses.
